// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch (IF) and memory-access (MA) request ports, the shared memory
// port and the stall/error outputs of mem_port_arbiter.
//   slave  : the arbiter's view. It receives requests and memory responses and
//            drives ready/rdata, stalls, the memory access fields and err.
//   master : the surrounding pipeline and memory model. It drives requests and
//            memory responses and observes everything else.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    // Memory-access stage port
    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic              ma_ready;
    logic [DATA_W-1:0] ma_rdata;
    // Pipeline stalls
    logic              stall_if;
    logic              stall_ma;
    // Shared memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    // Timeout abort
    logic              err;

    modport slave (
        input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
        output if_ready, if_rdata, ma_ready, ma_rdata, stall_if, stall_ma,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ack,
        input  if_ready, if_rdata, ma_ready, ma_rdata, stall_if, stall_ma,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between an instruction-fetch requester (IF) and a
// memory-access stage requester (MA). MA has priority, except that after
// STARVE_MAX back-to-back MA grants made while IF was waiting, IF is served once.
// A granted access latches its fields into mem_addr/mem_we/mem_wdata and raises
// mem_req from the next cycle until mem_ack or a timeout ends it.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: requester handshakes, memory port,
//          stall_if/stall_ma and the err timeout pulse
// Timing: a request granted in cycle N gives mem_req=1 from N+1. The requester's
// ready pulse is combinational from mem_ack, so the earliest completion is N+1.
// If no ack arrives in the first TIMEOUT busy cycles, the next busy cycle aborts
// with err + ready and all-ones read data.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX      = SW'(STARVE_MAX);
    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_MA = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [7:0]        wait_q;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;

    logic busy;
    logic timeout;
    logic done;
    logic grant_ma;
    logic grant_if;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= SMAX) ? v : v + 1'b1;
    endfunction

    assign busy     = (state_q != IDLE);
    // An ack in the timeout cycle still completes the access normally.
    assign timeout  = busy && !bus.mem_ack && (wait_q == TIMEOUT_C);
    assign done     = busy && (bus.mem_ack || (wait_q == TIMEOUT_C));

    assign grant_ma = (state_q == IDLE) && bus.ma_req && (!bus.if_req || (starve_q < SMAX));
    assign grant_if = (state_q == IDLE) && !grant_ma && bus.if_req;

    // MA grants only count against IF while IF is actually waiting.
    assign starve_d = bus.if_req ? sat_inc(starve_q) : '0;

    // Completion pulses are gated by rst so a reset cycle never reports completion.
    assign bus.if_ready = (state_q == BUSY_IF) && done && !rst;
    assign bus.ma_ready = (state_q == BUSY_MA) && done && !rst;
    assign bus.err      = timeout && !rst;

    assign bus.if_rdata = !bus.if_ready ? '0 :
                          timeout       ? '1 : bus.mem_rdata;
    assign bus.ma_rdata = !bus.ma_ready ? '0 :
                          timeout       ? '1 :
                          mem_we_q      ? '0 : bus.mem_rdata;

    assign bus.stall_if = bus.if_req & ~bus.if_ready;
    assign bus.stall_ma = bus.ma_req & ~bus.ma_ready;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wait_q      <= '0;
            starve_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_ma) begin
                        state_q     <= BUSY_MA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.ma_we;
                        mem_addr_q  <= bus.ma_addr;
                        mem_wdata_q <= bus.ma_wdata;
                        wait_q      <= '0;
                        starve_q    <= starve_d;
                    end else if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        wait_q      <= '0;
                        starve_q    <= '0;
                    end
                end
                default: begin
                    if (done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        wait_q    <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a directed cycle table, two hand-written
// multi-cycle sequences (round-robin under starvation, timeout abort) and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;
    localparam int SM = 4;
    localparam int NV = 19;
    localparam int NRAND = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ma_req    = 1'b0;
        bus.ma_we     = 1'b0;
        bus.ma_addr   = '0;
        bus.ma_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // One row = one clock cycle: inputs applied, then outputs expected that cycle.
    typedef struct {
        logic          rst;
        logic          ifr;
        logic [AW-1:0] ifa;
        logic          mar;
        logic          mwe;
        logic [AW-1:0] maa;
        logic [DW-1:0] mwd;
        logic          ack;
        logic [DW-1:0] rd;
        logic          e_ifr;
        logic [DW-1:0] e_ifd;
        logic          e_mar;
        logic [DW-1:0] e_mad;
        logic          e_mreq;
        logic          e_mwe;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_mwd;
        logic          e_err;
    } vec_t;

    vec_t vt [NV];

    // Reference model state (transaction level: who owns the port, how long).
    int            m_owner;   // 0 none, 1 fetch, 2 memory-access stage
    int            m_age;
    int            m_starve;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          if_pend, ma_pend;
    int            mode;
    logic          x_fin, x_to, x_ifr, x_mar, x_err;
    logic [DW-1:0] x_data;
    int            who [$];
    int            err_cyc;
    int            ma_stop;

    initial begin
        //          rst   ifr   ifa       mar   mwe   maa       mwd       ack   rd          e_ifr e_ifd     e_mar e_mad     mreq  mwe   e_ma      e_mwd     err
        vt[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234,  1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5555,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 16'h0080, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 16'h7777,  1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0};
        vt[10] = '{1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0};
        vt[11] = '{1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5,  1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b0};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0080, 16'h0000, 1'b0};
        vt[13] = '{1'b0, 1'b1, 16'h00C0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0080, 16'h0000, 1'b0};
        vt[14] = '{1'b1, 1'b1, 16'h00C0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h00C0, 16'h0000, 1'b0};
        vt[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h3333, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h3333, 1'b1, 16'h4321,  1'b0, 16'h0000, 1'b1, 16'h4321, 1'b1, 1'b0, 16'h0200, 16'h3333, 1'b0};
        vt[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h3333, 1'b0};

        // ---------------- power-up reset ----------------
        zero_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();

        // ---------------- directed table ----------------
        for (int i = 0; i < NV; i++) begin
            rst           = vt[i].rst;
            bus.if_req    = vt[i].ifr;
            bus.if_addr   = vt[i].ifa;
            bus.ma_req    = vt[i].mar;
            bus.ma_we     = vt[i].mwe;
            bus.ma_addr   = vt[i].maa;
            bus.ma_wdata  = vt[i].mwd;
            bus.mem_ack   = vt[i].ack;
            bus.mem_rdata = vt[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d.if_ready", i),  32'(bus.if_ready),  32'(vt[i].e_ifr));
            chk($sformatf("v%0d.ma_ready", i),  32'(bus.ma_ready),  32'(vt[i].e_mar));
            chk($sformatf("v%0d.mem_req", i),   32'(bus.mem_req),   32'(vt[i].e_mreq));
            chk($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),    32'(vt[i].e_mwe));
            chk($sformatf("v%0d.mem_addr", i),  32'(bus.mem_addr),  32'(vt[i].e_ma));
            chk($sformatf("v%0d.mem_wdata", i), 32'(bus.mem_wdata), 32'(vt[i].e_mwd));
            chk($sformatf("v%0d.err", i),       32'(bus.err),       32'(vt[i].e_err));
            chk($sformatf("v%0d.stall_if", i),  32'(bus.stall_if),  32'(vt[i].ifr & ~vt[i].e_ifr));
            chk($sformatf("v%0d.stall_ma", i),  32'(bus.stall_ma),  32'(vt[i].mar & ~vt[i].e_mar));
            if (vt[i].e_ifr) chk($sformatf("v%0d.if_rdata", i), 32'(bus.if_rdata), 32'(vt[i].e_ifd));
            if (vt[i].e_mar) chk($sformatf("v%0d.ma_rdata", i), 32'(bus.ma_rdata), 32'(vt[i].e_mad));
            next_cycle();
        end
        rst = 1'b0;

        // ---------------- both requesters held, immediate ack ----------------
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0444;
        bus.ma_req  = 1'b1;
        bus.ma_we   = 1'b0;
        bus.ma_addr = 16'h0888;
        bus.mem_ack = 1'b1;
        who.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("rr.excl", 32'(bus.if_ready & bus.ma_ready), 32'd0);
            if (bus.ma_ready) who.push_back(2);
            if (bus.if_ready) who.push_back(1);
            next_cycle();
        end
        chk("rr.count", 32'(who.size()), 32'd15);
        for (int i = 0; i < who.size(); i++)
            chk($sformatf("rr.grant%0d", i), 32'(who[i]), (i % (SM + 1) == SM) ? 32'd1 : 32'd2);

        // ---------------- timeout abort ----------------
        do_reset();
        bus.ma_req   = 1'b1;
        bus.ma_we    = 1'b0;
        bus.ma_addr  = 16'h0300;
        bus.mem_rdata = 16'h1357;
        err_cyc = -1;
        ma_stop = 0;
        for (int c = 0; c < 40 && ma_stop == 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("to.mem_req_c0", 32'(bus.mem_req), 32'd0);
            if (c == 1) chk("to.mem_req_c1", 32'(bus.mem_req), 32'd1);
            if (bus.err) begin
                err_cyc = c;
                chk("to.ma_ready", 32'(bus.ma_ready), 32'd1);
                chk("to.ma_rdata", 32'(bus.ma_rdata), 32'h0000FFFF);
                chk("to.mem_req",  32'(bus.mem_req),  32'd1);
                ma_stop = 1;
            end else begin
                chk($sformatf("to.early_ready%0d", c), 32'(bus.ma_ready), 32'd0);
            end
            next_cycle();
        end
        chk("to.err_cycle", 32'(err_cyc), 32'(TO + 1));
        bus.ma_req = 1'b0;
        @(negedge clk);
        chk("to.mem_req_after", 32'(bus.mem_req), 32'd0);
        chk("to.err_after",     32'(bus.err),     32'd0);
        next_cycle();

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_owner = 0; m_age = 0; m_starve = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        if_pend = 1'b0; ma_pend = 1'b0; mode = 0;
        for (int cyc = 0; cyc < NRAND; cyc++) begin
            if (cyc % 250 == 0) mode = $urandom_range(0, 1);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend     = 1'b1;
                bus.if_addr = 16'($urandom);
            end
            if (!ma_pend && $urandom_range(0, 2) == 0) begin
                ma_pend      = 1'b1;
                bus.ma_we    = 1'($urandom_range(0, 1));
                bus.ma_addr  = 16'($urandom);
                bus.ma_wdata = 16'($urandom);
            end
            bus.if_req    = if_pend;
            bus.ma_req    = ma_pend;
            bus.mem_ack   = (mode == 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
            bus.mem_rdata = 16'($urandom);
            rst           = ($urandom_range(0, 399) == 0);

            x_fin  = (m_owner != 0) && (bus.mem_ack || m_age >= TO);
            x_to   = (m_owner != 0) && !bus.mem_ack && m_age >= TO;
            x_ifr  = !rst && m_owner == 1 && x_fin;
            x_mar  = !rst && m_owner == 2 && x_fin;
            x_err  = !rst && x_to;
            x_data = x_to ? 16'hFFFF : ((m_owner == 2 && m_we) ? 16'h0000 : bus.mem_rdata);

            @(negedge clk);
            chk($sformatf("r%0d.if_ready", cyc),  32'(bus.if_ready),  32'(x_ifr));
            chk($sformatf("r%0d.ma_ready", cyc),  32'(bus.ma_ready),  32'(x_mar));
            chk($sformatf("r%0d.err", cyc),       32'(bus.err),       32'(x_err));
            chk($sformatf("r%0d.mem_req", cyc),   32'(bus.mem_req),   32'(m_owner != 0));
            chk($sformatf("r%0d.mem_we", cyc),    32'(bus.mem_we),    32'(m_we));
            chk($sformatf("r%0d.mem_addr", cyc),  32'(bus.mem_addr),  32'(m_addr));
            chk($sformatf("r%0d.mem_wdata", cyc), 32'(bus.mem_wdata), 32'(m_wdata));
            chk($sformatf("r%0d.stall_if", cyc),  32'(bus.stall_if),  32'(if_pend & ~x_ifr));
            chk($sformatf("r%0d.stall_ma", cyc),  32'(bus.stall_ma),  32'(ma_pend & ~x_mar));
            if (x_ifr) chk($sformatf("r%0d.if_rdata", cyc), 32'(bus.if_rdata), 32'(x_data));
            if (x_mar) chk($sformatf("r%0d.ma_rdata", cyc), 32'(bus.ma_rdata), 32'(x_data));

            if (rst) begin
                m_owner = 0; m_age = 0; m_starve = 0;
                m_we = 1'b0; m_addr = '0; m_wdata = '0;
            end else if (m_owner == 0) begin
                if (ma_pend && (!if_pend || m_starve < SM)) begin
                    m_owner  = 2;
                    m_age    = 0;
                    m_we     = bus.ma_we;
                    m_addr   = bus.ma_addr;
                    m_wdata  = bus.ma_wdata;
                    m_starve = if_pend ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
                end else if (if_pend) begin
                    m_owner  = 1;
                    m_age    = 0;
                    m_we     = 1'b0;
                    m_addr   = bus.if_addr;
                    m_wdata  = '0;
                    m_starve = 0;
                end
            end else if (x_fin) begin
                m_owner = 0;
                m_age   = 0;
            end else begin
                m_age++;
            end
            if (x_ifr) if_pend = 1'b0;
            if (x_mar) ma_pend = 1'b0;
            next_cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
